// File: rtl/rv32m_muldiv_seq.sv
// rv32m_muldiv_seq - iterative RISC-V M-extension multiply/divide unit.
//
// Radix-2 shift-add multiply and restoring divide on magnitudes. A final
// FIX cycle applies the sign and picks the result half. Divide-by-zero
// and signed-overflow divides are resolved at accept time and go straight
// to DONE.
//
// Optional feature macro: MULDIV_DIV_EN
//   defined   : full divide datapath, DIV state and special-case logic.
//   undefined : opcodes 4-7 are accepted and return 0 with latency 1.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   kill                  abandon in-flight op, return to IDLE
//   req_valid/req_ready   request handshake (req_ready = IDLE && !kill)
//   req_opc               funct3: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//   req_src1, req_src2    rs1 / rs2 operands
//   rsp_valid/rsp_ready   response handshake, result held while stalled
//   rsp_result            registered result
//   busy                  high in any state other than IDLE
module rv32m_muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            kill,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_opc,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic [2*XLEN-1:0]   acc;       // product, or {remainder, quotient}
  logic [XLEN-1:0]     opnd;      // multiplicand or divisor magnitude
  logic                neg_q;     // negate the selected result in FIX
  logic                hi_q;      // select upper half (MULH*, REM*)

  logic                accept, is_mul, sgn1, sgn2, neg1, neg2, res_neg;
  logic [XLEN-1:0]     mag1, mag2;
  logic                special;
  logic [XLEN-1:0]     special_res;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_nxt, prod;
  logic [XLEN-1:0]     fix_res;

  assign req_ready = (state == IDLE) && !kill;
  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;
  assign is_mul    = !req_opc[2];

  // Signedness: MULH, DIV, REM fully signed; MULHSU signs rs1 only.
  assign sgn1    = (req_opc == 3'd1) || (req_opc == 3'd2) || (req_opc == 3'd4) || (req_opc == 3'd6);
  assign sgn2    = (req_opc == 3'd1) || (req_opc == 3'd4) || (req_opc == 3'd6);
  assign neg1    = sgn1 && req_src1[XLEN-1];
  assign neg2    = sgn2 && req_src2[XLEN-1];
  assign mag1    = neg1 ? -req_src1 : req_src1;
  assign mag2    = neg2 ? -req_src2 : req_src2;
  // Signed remainder follows the dividend; everything else is sign1^sign2.
  assign res_neg = (req_opc == 3'd6) ? neg1 : (neg1 ^ neg2);

`ifdef MULDIV_DIV_EN
  logic              div_q;
  logic [XLEN:0]     part;
  logic [XLEN+1:0]   diff;
  logic [2*XLEN-1:0] div_nxt;
  logic [XLEN-1:0]   half;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path
    // can leave it unassigned and infer a latch.
    special     = 1'b0;
    special_res = '0;
    if (req_opc[2]) begin
      if (req_src2 == '0) begin
        special     = 1'b1;
        special_res = req_opc[1] ? req_src1 : '1;
      end else if (!req_opc[0] && req_src1 == {1'b1, {(XLEN-1){1'b0}}} && req_src2 == '1) begin
        special     = 1'b1;
        special_res = req_opc[1] ? '0 : req_src1;
      end
    end
  end

  // Restoring step: the partial remainder is XLEN+1 bits wide because the
  // shift can carry the remainder's top bit out of the upper half.
  assign part    = acc[2*XLEN-1:XLEN-1];
  assign diff    = {1'b0, part} - {2'b00, opnd};
  assign div_nxt = diff[XLEN+1] ? {part[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
`else
  assign special     = req_opc[2];
  assign special_res = '0;
`endif

  // Shift-add step: carry out of the upper-half add re-enters on the shift.
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
  assign mul_nxt = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};

  always_comb begin
    prod    = neg_q ? -acc : acc;
    fix_res = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
`ifdef MULDIV_DIV_EN
    // Quotient and remainder are negated individually, not as a pair.
    half = hi_q ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    if (div_q) fix_res = neg_q ? -half : half;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = special ? DONE : (is_mul ? MUL : DIV);
      MUL, DIV: if (cnt == '0) state_nxt = FIX;
      FIX:      state_nxt = DONE;
      DONE:     if (rsp_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      rsp_result <= '0;
    end else if (accept) begin
      cnt <= CW'(XLEN - 1);
      if (special) rsp_result <= special_res;
    end else if (state == MUL || state == DIV) begin
      cnt <= cnt - 1'b1;
    end else if (state == FIX && !kill) begin
      rsp_result <= fix_res;
    end
  end

  // NOTE: the datapath is not reset; it is fully loaded on every accept
  // and never observed before that.
  always_ff @(posedge clk) begin
    if (accept) begin
      opnd  <= is_mul ? mag1 : mag2;
      acc   <= {{XLEN{1'b0}}, is_mul ? mag2 : mag1};
      neg_q <= res_neg;
      hi_q  <= is_mul ? (req_opc[1:0] != 2'b00) : req_opc[1];
`ifdef MULDIV_DIV_EN
      div_q <= req_opc[2];
`endif
    end else if (state == MUL) begin
      acc <= mul_nxt;
`ifdef MULDIV_DIV_EN
    end else if (state == DIV) begin
      acc <= div_nxt;
`endif
    end
  end

endmodule

// File: doc/rv32m_muldiv_seq.md
# rv32m_muldiv_seq

Iterative, parametrised multiply/divide unit implementing the RISC-V M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits in the EXE stage beside the single-cycle RV32I ALU. It accepts one operation at a time over a valid/ready request port and returns the result over a valid/ready response port after a fixed multi-cycle latency. The design is radix-2 shift-add for multiply and restoring division for divide, with sign handling in a final fix-up cycle.

## Interface
Parameters:
- XLEN, 32 — operand and result width; legal values 32 or 64.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- kill  in  1  abandon the in-flight operation (pipeline flush).
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; equals (state==IDLE) && !kill.
- req_opc  in  3  RISC-V funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- req_src1  in  XLEN  rs1 operand (multiplicand/dividend).
- req_src2  in  XLEN  rs2 operand (multiplier/divisor).
- rsp_valid  out  1  result available; held until accepted.
- rsp_ready  in  1  consumer accepts result.
- rsp_result  out  XLEN  result; stable while rsp_valid && !rsp_ready.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- Reset: state=IDLE. Outputs: req_ready=1 (if kill=0), rsp_valid=0, rsp_result=0, busy=0. Iteration counter=0.
- Accept: req_valid && req_ready at a posedge latches opc and operands.
  - Operands are converted to magnitudes per signedness. MULH: both signed. MULHSU: src1 signed, src2 unsigned. DIV/REM: both signed. Others: unsigned.
  - Result sign is recorded.
- MUL: XLEN iterations. Each iteration conditionally adds the multiplicand into the upper half of a 2*XLEN accumulator, then shifts right by 1.
- DIV: XLEN iterations of a restoring step on a 2*XLEN remainder/quotient register. Counter counts XLEN-1 down to 0.
- FIX: conditionally negates the 2*XLEN product, quotient, or remainder.
  - Remainder takes the dividend's sign.
  - MUL selects the low half; MULH/MULHSU/MULHU select the high half.
  - The result is registered into rsp_result.
- DONE: rsp_valid=1. On rsp_ready, return to IDLE and drop rsp_valid.
- Special cases are decided at accept time. They skip iteration and go straight to DONE.
  - Divisor==0: DIV/DIVU → all ones; REM/REMU → src1.
  - Signed overflow (src1 = most-negative, src2 = all ones): DIV → src1; REM → 0.
- kill: from any state, next state is IDLE with rsp_valid=0 and no result delivered.
  - kill in IDLE blocks acceptance that cycle, because req_ready=0.
  - kill overrides a simultaneous rsp_ready; the response counts as not delivered.
- reset mid-operation behaves as kill and also clears rsp_result to 0.
- Requests arriving while busy are not accepted. The producer must hold them, and the unit never drops an accepted request.

## Timing
- Request accepted at posedge N.
- Iterated ops: states MUL/DIV during cycles N+1..N+XLEN, FIX at N+XLEN+1. rsp_valid is high from posedge N+XLEN+2. Latency is XLEN+2 cycles (34 for XLEN=32).
- Special-case divides: rsp_valid is high from posedge N+1. Latency is 1.
- Earliest next accept is the posedge after the rsp handshake. req_ready is 1 in the cycle following rsp_valid && rsp_ready.
- Throughput is one op per XLEN+3 cycles with rsp_ready tied high.
- Backpressure: rsp_result and rsp_valid hold indefinitely in DONE while rsp_ready=0.

## Configuration
- MULDIV_DIV_EN defined: full divide datapath, DIV state, and special-case logic.
- MULDIV_DIV_EN undefined: divide logic is not compiled in.
  - Opcodes 4–7 are still accepted and return rsp_result=0 with latency 1 (direct to DONE).
  - Multiply behaviour and timing are unchanged.

## Test plan
(XLEN=32, rsp_ready tied high unless stated.)
- MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB, rsp_valid exactly 34 cycles after accept. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH 0x80000000 × 0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM of the same → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2. All at latency 34.
- DIVU 5 / 0 → 0xFFFFFFFF and REM 5 / 0 → 5, each at latency 1. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM of the same → 0, each at latency 1.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid.
  - rsp_result must stay constant, req_ready=0 and busy=1 throughout.
  - After the handshake, req_ready=1 on the next cycle.
- Pulse kill at iteration 10 of a DIV. Unit reaches IDLE next cycle, no rsp_valid appears, and a following MUL 3 × 4 → 12 completes normally. Repeat with reset instead: rsp_result reads 0.
- Random regression: 10000 mixed ops with random rsp_ready stalls, compared against a behavioural model. Build with and without MULDIV_DIV_EN; when undefined, ops 4–7 → 0 at latency 1.
